// File: rtl/manchester_frame_scheduler.sv
// Round-robin scheduler that feeds one Manchester serializer from NUM_REQ sources.
// Each frame is {PREAMBLE, SFD, payload} shifted MSB-first, then an idle gap.
module manchester_frame_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PAYLOAD_W  = 32,
  parameter logic [15:0] PREAMBLE   = 16'hAAAA,
  parameter logic [7:0]  SFD        = 8'hD5,
  parameter int unsigned GAP_BITS   = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                              clk108,
  input  logic                              aresetn,
  input  logic                              enable,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]      req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              data_bit,
  output logic                              tx_active,
  output logic                              frame_start,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic [15:0]                       frames_sent
);

  localparam int unsigned FRAME_W = 16 + 8 + PAYLOAD_W;
  localparam int unsigned GW      = $clog2(NUM_REQ);
  localparam int unsigned KW      = $clog2(FRAME_W);
  localparam int unsigned CW      = 8;
  localparam int unsigned CNT_W   = 16;

  localparam logic [KW-1:0] LAST_BIT = KW'(FRAME_W - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'(GAP_BITS - 1);
  localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        gap_q, gap_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        gid_q, gid_d;
  logic [CNT_W-1:0]     fs_q, fs_d;
  logic                 data_bit_q, data_bit_d;
  logic                 tx_active_q, tx_active_d;
  logic                 frame_start_q, frame_start_d;

  logic                 hi_found, lo_found;
  logic [GW-1:0]        hi_sel, lo_sel, gsel;
  logic [PAYLOAD_W-1:0] payload;
  logic                 grant;
  logic [FRAME_W-1:0]   frame;

  // Round-robin pick: lowest valid index at/after the pointer, else lowest valid overall.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_sel    = '0;
    lo_sel    = '0;
    payload   = '0;
    req_ready = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_sel   = GW'(i);
        if (GW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_sel   = GW'(i);
        end
      end
    end
    gsel  = hi_found ? hi_sel : lo_sel;
    grant = aresetn && enable && (state_q == IDLE) && lo_found;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (GW'(i) == gsel) begin
        payload      = req_data[i*PAYLOAD_W +: PAYLOAD_W];
        req_ready[i] = grant;
      end
    end
  end

  // Next-state and registered-output logic for IDLE -> SEND -> GAP -> IDLE.
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    k_d           = k_q;
    gap_d         = gap_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    fs_d          = fs_q;
    data_bit_d    = IDLE_LEVEL;
    tx_active_d   = 1'b0;
    frame_start_d = 1'b0;
    frame         = {PREAMBLE, SFD, payload};
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          data_bit_d    = frame[FRAME_W-1];
          sh_d          = {frame[FRAME_W-2:0], 1'b0};
          tx_active_d   = 1'b1;
          frame_start_d = 1'b1;
          k_d           = '0;
          gid_d         = gsel;
          ptr_d         = (gsel == LAST_REQ) ? '0 : gsel + GW'(1);
          state_d       = SEND;
        end
      end
      SEND: begin
        if (k_q == LAST_BIT) begin
          state_d = GAP;
          gap_d   = '0;
          fs_d    = fs_q + CNT_W'(1);
        end else begin
          data_bit_d  = sh_q[FRAME_W-1];
          sh_d        = {sh_q[FRAME_W-2:0], 1'b0};
          tx_active_d = 1'b1;
          k_d         = k_q + KW'(1);
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk108) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      k_q           <= '0;
      gap_q         <= '0;
      ptr_q         <= '0;
      gid_q         <= '0;
      fs_q          <= '0;
      data_bit_q    <= IDLE_LEVEL;
      tx_active_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      k_q           <= k_d;
      gap_q         <= gap_d;
      ptr_q         <= ptr_d;
      gid_q         <= gid_d;
      fs_q          <= fs_d;
      data_bit_q    <= data_bit_d;
      tx_active_q   <= tx_active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign data_bit    = data_bit_q;
  assign tx_active   = tx_active_q;
  assign frame_start = frame_start_q;
  assign grant_id    = gid_q;
  assign frames_sent = fs_q;

endmodule

// File: tb/tb_manchester_frame_scheduler.sv
// Self-checking bench: table-driven single frames, directed corner sequences and
// random traffic, all checked against a frame-timeline reference model.
module tb_manchester_frame_scheduler;

  localparam int N   = 4;
  localparam int PW  = 32;
  localparam int GAP = 8;
  localparam int FL  = 56;

  logic            clk108 = 1'b0;
  logic            aresetn;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            data_bit;
  logic            tx_active;
  logic            frame_start;
  logic [1:0]      grant_id;
  logic [15:0]     frames_sent;

  always #5 clk108 = ~clk108;

  manchester_frame_scheduler dut (
    .clk108      (clk108),
    .aresetn     (aresetn),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .data_bit    (data_bit),
    .tx_active   (tx_active),
    .frame_start (frame_start),
    .grant_id    (grant_id),
    .frames_sent (frames_sent)
  );

  int checks = 0;
  int errors = 0;

  // Expected per-cycle line state, queued when a handshake is predicted.
  typedef struct {
    logic b;
    logic act;
    logic start;
    logic last;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mcnt;
  logic [1:0]  mgid;
  int          mptr;
  int          cyc;
  int          glog_idx[$];
  int          glog_cyc[$];

  logic        s_bit, s_act, s_start;
  logic [N-1:0] s_rdy;
  logic [1:0]  s_gid;
  logic [15:0] s_fs;

  typedef struct {
    int          idx;
    logic [31:0] pay;
    logic [55:0] frame;
    logic [1:0]  gid;
    logic [15:0] fs;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of the reference: compare outputs, then predict handshake/reset effects.
  task automatic model_step();
    ent_t        e;
    bit          idle;
    int          g;
    logic [N-1:0] exp_rdy;
    logic [55:0] fr;
    idle    = (mq.size() == 0);
    e.b     = 1'b0;
    e.act   = 1'b0;
    e.start = 1'b0;
    e.last  = 1'b0;
    if (!idle) e = mq.pop_front();
    s_bit   = data_bit;
    s_act   = tx_active;
    s_start = frame_start;
    s_rdy   = req_ready;
    s_gid   = grant_id;
    s_fs    = frames_sent;
    chk("data_bit", 64'(s_bit), 64'(e.b));
    chk("tx_active", 64'(s_act), 64'(e.act));
    chk("frame_start", 64'(s_start), 64'(e.start));
    chk("frames_sent", 64'(s_fs), 64'(mcnt));
    chk("grant_id", 64'(s_gid), 64'(mgid));
    g = -1;
    if (idle && aresetn && enable) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[(mptr + i) % N]) begin
          g = (mptr + i) % N;
          break;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(s_rdy), 64'(exp_rdy));
    if (e.last) mcnt = mcnt + 16'd1;
    if (g >= 0) begin
      fr = {16'hAAAA, 8'hD5, req_data[g*PW +: PW]};
      for (int k = 0; k < FL; k++) begin
        e.b = fr[FL-1-k]; e.act = 1'b1; e.start = (k == 0); e.last = (k == FL-1);
        mq.push_back(e);
      end
      for (int k = 0; k < GAP; k++) begin
        e.b = 1'b0; e.act = 1'b0; e.start = 1'b0; e.last = 1'b0;
        mq.push_back(e);
      end
      mgid = 2'(g);
      mptr = (g + 1) % N;
      glog_idx.push_back(g);
      glog_cyc.push_back(cyc);
    end
    if (!aresetn) begin
      mq.delete();
      mcnt = '0;
      mgid = '0;
      mptr = 0;
    end
    cyc++;
  endtask

  // Inputs are set just after a falling edge; outputs sampled 2 time units later.
  task automatic tick();
    #2;
    model_step();
    @(negedge clk108);
  endtask

  task automatic wait_grant(input int idx);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      tick();
      got = s_rdy[idx];
    end
    chk("grant_wait", 64'(got), 64'd1);
  endtask

  task automatic capture(input int drop_k, output logic [55:0] cap, output int act_cnt);
    cap = '0;
    act_cnt = 0;
    for (int k = 0; k < FL; k++) begin
      if (k == drop_k) enable = 1'b0;
      tick();
      cap = {cap[54:0], s_bit};
      act_cnt += int'(s_act);
      if (k == 0) chk("first_bit_start", 64'(s_start), 64'd1);
    end
  endtask

  initial begin
    logic [55:0] cap;
    int          act_cnt;
    int          base;
    int          rr_exp[5];
    bit          done;

    tbl[0] = '{1, 32'hAABBCCDD, 56'hAAAAD5AABBCCDD, 2'd1, 16'd1};
    tbl[1] = '{3, 32'h00000000, 56'hAAAAD500000000, 2'd3, 16'd2};
    tbl[2] = '{0, 32'hFFFFFFFF, 56'hAAAAD5FFFFFFFF, 2'd0, 16'd3};
    tbl[3] = '{2, 32'h12345678, 56'hAAAAD512345678, 2'd2, 16'd4};
    rr_exp = '{0, 1, 2, 3, 0};

    aresetn   = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    mcnt = '0; mgid = '0; mptr = 0; cyc = 0;
    @(negedge clk108);
    tick();
    tick();
    aresetn = 1'b1;

    // Single-frame vectors
    for (int v = 0; v < 4; v++) begin
      req_data[tbl[v].idx*PW +: PW] = tbl[v].pay;
      req_valid = '0;
      req_valid[tbl[v].idx] = 1'b1;
      wait_grant(tbl[v].idx);
      req_valid = '0;
      capture(-1, cap, act_cnt);
      chk("frame_bits", 64'(cap), 64'(tbl[v].frame));
      chk("active_len", 64'(act_cnt), 64'd56);
      repeat (GAP) tick();
      chk("vec_grant_id", 64'(s_gid), 64'(tbl[v].gid));
      chk("vec_frames_sent", 64'(s_fs), 64'(tbl[v].fs));
    end

    // Round-robin with all requesters held valid, starting from a fresh pointer
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    req_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_valid = '1;
    base = glog_idx.size();
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      done = (glog_idx.size() >= base + 5);
    end
    chk("rr_done", 64'(done), 64'd1);
    req_valid = '0;
    if (done) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", 64'(glog_idx[base+i]), 64'(rr_exp[i]));
        if (i > 0) chk("rr_spacing", 64'(glog_cyc[base+i] - glog_cyc[base+i-1]), 64'd65);
      end
    end
    repeat (70) tick();

    // Reset in the middle of a frame for requester 2
    req_data[2*PW +: PW] = 32'hCAFEF00D;
    req_valid = 4'b0100;
    wait_grant(2);
    repeat (20) tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    chk("rst_data_bit", 64'(s_bit), 64'd0);
    chk("rst_tx_active", 64'(s_act), 64'd0);
    chk("rst_frames_sent", 64'(s_fs), 64'd0);
    chk("rst_regrant", 64'(s_rdy), 64'b0100);
    req_valid = '0;
    repeat (70) tick();

    // Enable dropped mid-frame; payload changed after its handshake
    req_data[0 +: PW] = 32'h5EED1234;
    req_valid = 4'b0001;
    wait_grant(0);
    req_valid = 4'b1000;
    req_data[0 +: PW] = 32'hDEADBEEF;
    req_data[3*PW +: PW] = 32'h0BADCAFE;
    capture(10, cap, act_cnt);
    chk("gated_frame", 64'(cap), 64'h00AAAAD55EED1234);
    chk("gated_active_len", 64'(act_cnt), 64'd56);
    for (int n = 0; n < GAP + 20; n++) begin
      tick();
      chk("gated_no_ready", 64'(s_rdy), 64'd0);
    end
    enable = 1'b1;
    tick();
    chk("enable_regrant", 64'(s_rdy), 64'b1000);
    req_valid = '0;

    // Counter wrap via preload
    repeat (5) tick();
    force dut.fs_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    repeat (3) tick();
    release dut.fs_q;
    tick();
    chk("preload", 64'(s_fs), 64'hFFFF);
    repeat (70) tick();
    chk("wrap", 64'(s_fs), 64'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && s_rdy[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_data[i*PW +: PW] = $urandom;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*PW +: PW] = $urandom;
        end
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      aresetn = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
